// File: rtl/adc_average_meter.sv
`default_nettype none
// ============================================================================
// adc_average_meter: periodic ADC sampler, boxcar moving average, timed
// peak-hold and 8-LED thermometer bar.                     Revision: 1.0
// ============================================================================
module adc_average_meter #(
    parameter int SAMPLE_TICKS      = 12000,
    parameter int LOG2_DEPTH        = 3,
    parameter int PEAK_HOLD_SAMPLES = 500
) (
    input  logic       clock12MHz,
    input  logic       resetN,
    input  logic [9:0] value,
    output logic [9:0] average,
    output logic [9:0] peak,
    output logic       averageValid,
    output logic       sampleStrobe,
    output logic [7:0] bar
);

    localparam int C_DEPTH  = 1 << LOG2_DEPTH;
    localparam int C_TICK_W = $clog2(SAMPLE_TICKS);
    localparam int C_HOLD_W = (PEAK_HOLD_SAMPLES > 1) ? $clog2(PEAK_HOLD_SAMPLES) : 1;
    localparam int C_SUM_W  = 10 + LOG2_DEPTH;

    localparam logic [C_TICK_W-1:0]   C_TICK_LAST = C_TICK_W'(SAMPLE_TICKS - 1);
    localparam logic [C_HOLD_W-1:0]   C_HOLD_LAST = C_HOLD_W'(PEAK_HOLD_SAMPLES - 1);
    localparam logic [LOG2_DEPTH:0]   C_FILL_FULL = (LOG2_DEPTH + 1)'(C_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_ACCUM  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                 state_q;
    logic [C_TICK_W-1:0]    tick_cnt_q;
    logic [9:0]             sample_q;
    logic [9:0]             oldest_q;
    logic [C_SUM_W-1:0]     sum_q;
    logic [LOG2_DEPTH-1:0]  wr_ptr_q;
    logic [LOG2_DEPTH:0]    fill_q;
    logic [C_HOLD_W-1:0]    hold_cnt_q;
    logic [9:0]             average_q;
    logic [9:0]             peak_q;
    logic                   valid_q;
    logic                   strobe_q;
    logic [7:0]             bar_q;

    logic [9:0]             buffer [C_DEPTH];

    logic                   tick_wrap_d;
    logic [C_SUM_W-1:0]     sum_d;
    logic [9:0]             avg_d;
    logic [7:0]             bar_d;

    assign tick_wrap_d = (tick_cnt_q == C_TICK_LAST);
    assign sum_d       = sum_q + C_SUM_W'(sample_q) - C_SUM_W'(oldest_q);
    assign avg_d       = sum_q[C_SUM_W-1:LOG2_DEPTH];

    generate
        for (genvar i = 0; i < 8; i++) begin : g_bar
            assign bar_d[i] = (avg_d[9:7] >= 3'(i));
        end
    endgenerate

    // Window RAM is deliberately unreset; fill_q masks never-written entries.
    always_ff @(posedge clock12MHz) begin
        if (state_q == S_ACCUM) begin
            buffer[wr_ptr_q] <= sample_q;
        end
    end

    always_ff @(posedge clock12MHz or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            sample_q   <= '0;
            oldest_q   <= '0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            hold_cnt_q <= '0;
            average_q  <= '0;
            peak_q     <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            bar_q      <= 8'h01;
        end else begin
            tick_cnt_q <= tick_wrap_d ? '0 : tick_cnt_q + C_TICK_W'(1);
            strobe_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick_wrap_d) begin
                        sample_q <= value;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    oldest_q <= (fill_q < C_FILL_FULL) ? 10'd0 : buffer[wr_ptr_q];
                    state_q  <= S_ACCUM;
                end
                S_ACCUM: begin
                    sum_q    <= sum_d;
                    wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
                    if (fill_q < C_FILL_FULL) begin
                        fill_q <= fill_q + (LOG2_DEPTH + 1)'(1);
                    end
                    state_q  <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    average_q <= avg_d;
                    bar_q     <= bar_d;
                    strobe_q  <= 1'b1;
                    if (fill_q == C_FILL_FULL) begin
                        valid_q <= 1'b1;
                    end
                    if (sample_q >= peak_q || hold_cnt_q == C_HOLD_LAST) begin
                        peak_q     <= sample_q;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + C_HOLD_W'(1);
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign average      = average_q;
    assign peak         = peak_q;
    assign averageValid = valid_q;
    assign sampleStrobe = strobe_q;
    assign bar          = bar_q;

endmodule
`default_nettype wire

// File: doc/adc_average_meter.md
# adc_average_meter

Periodic sampler and smoother for the 10-bit ADC measurement bus that the ADC reader produces. The block sits directly downstream of that reader. At a fixed sample rate it snapshots `value` and keeps a 2^LOG2_DEPTH-sample boxcar moving average with a ring buffer. It also tracks a timed peak-hold and drives an 8-LED thermometer bar from the average for the iceFUN LED row.

## Interface
Parameters:
- `SAMPLE_TICKS`, 12000: clock cycles between samples (1 kHz at 12 MHz); legal range ≥ 4.
- `LOG2_DEPTH`, 3: log2 of averaging window (8 samples); legal range 1..6.
- `PEAK_HOLD_SAMPLES`, 500: samples a peak is held before it is re-seeded; legal range ≥ 1.

Ports:
- `clock12MHz`, in, 1: the single system clock; all logic on its rising edge.
- `resetN`, in, 1: asynchronous, active-low reset.
- `value`, in, 10: raw ADC measurement, unsigned, level-held by the upstream reader.
- `average`, out, 10: moving average, unsigned.
- `peak`, out, 10: peak-hold value.
- `averageValid`, out, 1: high once the window has filled, and stays high.
- `sampleStrobe`, out, 1: one-cycle pulse when `average` and `peak` update.
- `bar`, out, 8: thermometer display of `average[9:7]`.

## Operation
- Tick counter `tickCnt` counts 0..SAMPLE_TICKS-1 and wraps. Each wrap starts one sample sequence, so a new sequence begins every SAMPLE_TICKS cycles.
- The state machine is `S_IDLE` → `S_READ` → `S_ACCUM` → `S_OUTPUT` → `S_IDLE`. Each state lasts one cycle.
  - `S_IDLE`: on tick wrap, latch `value` into `sample` and go to `S_READ`.
  - `S_READ`: read `buffer[wrPtr]` into `oldest`. If `fill < 2^LOG2_DEPTH`, use 0 for `oldest` because the entry has never been written. No RAM reset is required.
  - `S_ACCUM`:
    - `sum <= sum + sample - oldest`. `sum` is 10+LOG2_DEPTH bits, unsigned, and never over- or underflows.
    - `buffer[wrPtr] <= sample`.
    - `wrPtr` increments modulo 2^LOG2_DEPTH.
    - `fill` saturates at 2^LOG2_DEPTH.
  - `S_OUTPUT`:
    - `average <= sum >> LOG2_DEPTH`, truncating.
    - Update `peak` and `holdCnt`.
    - Pulse `sampleStrobe`.
    - Set `averageValid` when `fill == 2^LOG2_DEPTH`.
- Before the window fills, `average` equals the sum of the samples so far divided by the full depth. It therefore ramps up, which is the intended behaviour.
- Peak-hold, evaluated in `S_OUTPUT` using `sample`:
  - If `sample >= peak`: `peak <= sample`, `holdCnt <= 0`.
  - Else if `holdCnt == PEAK_HOLD_SAMPLES-1`: `peak <= sample`, `holdCnt <= 0` (re-seed).
  - Else: `holdCnt <= holdCnt + 1`.
- The bar is registered and updates with `average`. `bar[i] = (average[9:7] >= i)` for i = 0..7, so `bar[0]` is always lit.
- `value` is sampled raw with no synchronizer, because it comes from the same clock domain. A byte-wise update mid-sample is accepted as-is.

## Timing
Reset (`resetN` low, asynchronous) values:
- All outputs are 0, except `bar = 8'h01`.
- Internal registers: `tickCnt = 0`, `wrPtr = 0`, `fill = 0`, `sum = 0`, `holdCnt = 0`, state `S_IDLE`.

Reset release:
- Release is synchronous to the next rising edge.
- The first tick wrap occurs SAMPLE_TICKS cycles after release.

Latency and strobe:
- `value` is captured on cycle T, the tick-wrap edge.
- `average`, `peak` and `bar` update, and `sampleStrobe` goes high, on cycle T+3.
- `sampleStrobe` lasts exactly one cycle per sample.
- `averageValid` rises together with the strobe of sample number 2^LOG2_DEPTH and stays high until reset.

Concurrency:
- `tickCnt` runs free during the sequence.
- Because SAMPLE_TICKS ≥ 4, a new wrap never overlaps a sequence in progress.

Reset mid-sequence:
- Aborts the sequence immediately.
- Buffer contents are retained but ignored, because `fill = 0`.

## Test plan
The bench uses SAMPLE_TICKS=4, LOG2_DEPTH=2 and PEAK_HOLD_SAMPLES=3 throughout.
- Reset then constant `value=400` → strobes arrive every 4 cycles, first one 3 cycles after the first wrap. `average` reads 100, 200, 300, 400. `averageValid` rises on the 4th strobe. `bar = 8'h0F` after the 4th strobe (400 >> 7 = 3).
- Full window at 400, then step to `value=0` → `average` reads 300, 200, 100, 0 on the next four strobes, and `bar` ends at `8'h01`.
- Samples 1023 ×4 → `average=1023`, `bar=8'hFF`, and `sum` is exactly 4092 with no overflow.
- Peak sequence 500, 100, 100, 100, 100 → `peak` reads 500, 500, 500, 100, 100. The third low sample re-seeds the peak, then it holds 100.
- Drive random `value` for 50 samples → `average` matches a floor(sum of the last 4 samples / 4) model every strobe, and `wrPtr` wrap is verified.
- Assert `resetN` low during `S_ACCUM` for 2 cycles → all outputs return to reset values immediately. After release the ramp restarts from `average=value/4`, with no stale buffer data.
